// File: rtl/shift_reg_taps.sv
// Enable-gated tapped delay line with flush, runtime tap select, flat tap bus,
// fill tracking and a recirculate (rotate) mode.
module shift_reg_taps #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4,
    // Derived widths; leave at their defaults.
    parameter int unsigned TSW   = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   recirc,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [TSW-1:0]         tap_sel,
    output logic [WIDTH-1:0]       data_out,
    output logic [WIDTH-1:0]       tap_out,
    output logic [WIDTH*DEPTH-1:0] taps_flat,
    output logic [CW-1:0]          fill_cnt,
    output logic                   full,
    output logic                   valid_out
);

    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CW-1:0]    fill_q;
    logic [CW-1:0]    fill_d;
    logic             valid_q;
    logic             valid_d;

    // Next state: clr beats en; recirc rotates the last stage back to the head.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        valid_d = 1'b0;
        if (clr) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = recirc ? stage_q[DEPTH-1] : data_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (!recirc && (fill_q != FILL_MAX)) begin
                fill_d = fill_q + CW'(1);
            end
            valid_d = (fill_d == FILL_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // Output views are decoded from registers only; out-of-range taps read 0.
    always_comb begin
        tap_out   = '0;
        taps_flat = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            taps_flat[k*WIDTH +: WIDTH] = stage_q[k];
            if (tap_sel == TSW'(k)) begin
                tap_out = stage_q[k];
            end
        end
    end

    assign data_out  = stage_q[DEPTH-1];
    assign fill_cnt  = fill_q;
    assign full      = (fill_q == FILL_MAX);
    assign valid_out = valid_q;

endmodule

// File: tb/tb_shift_reg_taps.sv
// Directed bench for shift_reg_taps: DEPTH=4 instance against a stage model and
// output scoreboard, plus a DEPTH=5 instance for tap range and mid-stream reset.
module tb_shift_reg_taps;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        rstn4, en4, rc4, clr4;
    logic [6:0]  din4;
    logic [1:0]  ts4;
    logic [6:0]  dout4, tap4;
    logic [27:0] taps4;
    logic [2:0]  fill4;
    logic        full4, valid4;

    shift_reg_taps #(.WIDTH(7), .DEPTH(4)) u4 (
        .clk(clk), .rstn(rstn4), .en(en4), .recirc(rc4), .clr(clr4),
        .data_in(din4), .tap_sel(ts4), .data_out(dout4), .tap_out(tap4),
        .taps_flat(taps4), .fill_cnt(fill4), .full(full4), .valid_out(valid4)
    );

    // DEPTH=5 instance
    logic        rstn5, en5, rc5, clr5;
    logic [6:0]  din5;
    logic [2:0]  ts5;
    logic [6:0]  dout5, tap5;
    logic [34:0] taps5;
    logic [2:0]  fill5;
    logic        full5, valid5;

    shift_reg_taps #(.WIDTH(7), .DEPTH(5)) u5 (
        .clk(clk), .rstn(rstn5), .en(en5), .recirc(rc5), .clr(clr5),
        .data_in(din5), .tap_sel(ts5), .data_out(dout5), .tap_out(tap5),
        .taps_flat(taps5), .fill_cnt(fill5), .full(full5), .valid_out(valid5)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] m4 [4];
    logic [2:0] mfill;
    logic       mvalid;
    logic [6:0] sbq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mflat();
        return {m4[3], m4[2], m4[1], m4[0]};
    endfunction

    // One clock on the DEPTH=4 instance: drive, advance model, check everything.
    task automatic step4(input logic r, input logic e, input logic rc, input logic c,
                         input logic [6:0] d);
        logic [6:0] top;
        rstn4 = r; en4 = e; rc4 = rc; clr4 = c; din4 = d;
        @(posedge clk);
        if (!r || c) begin
            for (int k = 0; k < 4; k++) m4[k] = '0;
            mfill  = '0;
            mvalid = 1'b0;
        end else if (e) begin
            top = m4[3];
            for (int k = 3; k > 0; k--) m4[k] = m4[k-1];
            m4[0] = rc ? top : d;
            if (!rc && mfill != 3'd4) mfill = mfill + 3'd1;
            mvalid = (mfill == 3'd4);
            if (mvalid) sbq.push_back(m4[3]);
        end else begin
            mvalid = 1'b0;
        end
        #1;
        chk("taps4", 64'(taps4), 64'(mflat()));
        chk("fill4", 64'(fill4), 64'(mfill));
        chk("full4", 64'(full4), 64'(mfill == 3'd4));
        chk("valid4", 64'(valid4), 64'(mvalid));
        chk("tap4", 64'(tap4), 64'(m4[ts4]));
        if (valid4 === 1'b1) begin
            if (sbq.size() == 0) chk("sb_underflow", 64'(valid4), 64'(0));
            else chk("sb_data4", 64'(dout4), 64'(sbq.pop_front()));
        end
    endtask

    initial begin
        rstn4 = 1'b0; en4 = 1'b0; rc4 = 1'b0; clr4 = 1'b0; din4 = '0; ts4 = '0;
        rstn5 = 1'b0; en5 = 1'b1; rc5 = 1'b0; clr5 = 1'b0; din5 = 7'd9; ts5 = '0;
        for (int k = 0; k < 4; k++) m4[k] = '0;
        mfill = '0; mvalid = 1'b0;

        // Reset held two cycles with en high and data present
        step4(1'b0, 1'b1, 1'b0, 1'b0, 7'd9);
        step4(1'b0, 1'b1, 1'b0, 1'b0, 7'd9);
        chk("rst_dout", 64'(dout4), 64'(0));
        chk("rst_taps", 64'(taps4), 64'(0));
        chk("rst_fill", 64'(fill4), 64'(0));
        chk("rst_valid", 64'(valid4), 64'(0));
        chk("rst5_taps", 64'(taps5), 64'(0));

        // Continuous fill
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd3);
        chk("t2_fill1", 64'(fill4), 64'(1));
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd1);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd5);
        chk("t2_novalid", 64'(valid4), 64'(0));
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd11);
        chk("t2_dout", 64'(dout4), 64'(3));
        chk("t2_flat_a", 64'(taps4), 64'({7'd3, 7'd1, 7'd5, 7'd11}));
        chk("t2_valid", 64'(valid4), 64'(1));
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd15);
        chk("t2_flat_b", 64'(taps4), 64'({7'd1, 7'd5, 7'd11, 7'd15}));
        chk("t2_fill_sat", 64'(fill4), 64'(4));

        // Gapped enable after a flush
        step4(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd3);
        step4(1'b1, 1'b0, 1'b0, 1'b0, 7'd99);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd1);
        step4(1'b1, 1'b0, 1'b0, 1'b0, 7'd98);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd5);
        step4(1'b1, 1'b0, 1'b0, 1'b0, 7'd97);
        chk("t3_dout_early", 64'(dout4), 64'(0));
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd11);
        chk("t3_dout", 64'(dout4), 64'(3));
        chk("t3_valid", 64'(valid4), 64'(1));
        step4(1'b1, 1'b0, 1'b0, 1'b0, 7'd96);
        chk("t3_hold_valid", 64'(valid4), 64'(0));
        chk("t3_hold_dout", 64'(dout4), 64'(3));

        // clr with en in the same cycle, then refill
        step4(1'b1, 1'b1, 1'b0, 1'b1, 7'd7);
        chk("t4_taps", 64'(taps4), 64'(0));
        chk("t4_fill", 64'(fill4), 64'(0));
        chk("t4_full", 64'(full4), 64'(0));
        for (int i = 0; i < 4; i++) begin
            ts4 = 2'(i);
            step4(1'b1, 1'b1, 1'b0, 1'b0, 7'(20 + i));
        end
        chk("t4_dout", 64'(dout4), 64'(20));
        chk("t4_flat", 64'(taps4), 64'({7'd20, 7'd21, 7'd22, 7'd23}));

        // Recirculate while full
        step4(1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd3);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd1);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd5);
        step4(1'b1, 1'b1, 1'b0, 1'b0, 7'd11);
        for (int i = 0; i < 4; i++) begin
            ts4 = 2'(3 - i);
            step4(1'b1, 1'b1, 1'b1, 1'b0, 7'd127);
            chk("t5_valid", 64'(valid4), 64'(1));
        end
        chk("t5_flat", 64'(taps4), 64'({7'd3, 7'd1, 7'd5, 7'd11}));
        chk("t5_fill", 64'(fill4), 64'(4));
        step4(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);

        // DEPTH=5: load 1..5, sweep tap_sel across and beyond range, then reset mid-stream
        rstn5 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din5 = 7'(i);
            @(posedge clk); #1;
        end
        en5 = 1'b0;
        chk("t6_fill", 64'(fill5), 64'(5));
        chk("t6_full", 64'(full5), 64'(1));
        chk("t6_valid", 64'(valid5), 64'(1));
        chk("t6_dout", 64'(dout5), 64'(1));
        for (int k = 0; k < 8; k++) begin
            ts5 = 3'(k);
            #1;
            chk($sformatf("t6_tap%0d", k), 64'(tap5), (k < 5) ? 64'(5 - k) : 64'(0));
        end
        rstn5 = 1'b0; en5 = 1'b1; din5 = 7'd9; ts5 = 3'd0;
        @(posedge clk); #1;
        chk("t6_rst_taps", 64'(taps5), 64'(0));
        chk("t6_rst_tap", 64'(tap5), 64'(0));
        chk("t6_rst_fill", 64'(fill5), 64'(0));
        chk("t6_rst_valid", 64'(valid5), 64'(0));

        chk("sb_leftover", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
